bcd_to_bin_seq: RTL and testbench
=================================

# bcd_to_bin_seq

Sequential BCD-to-binary converter: the inverse of the board's binary-to-BCD display path. It accepts a packed multi-digit BCD value, such as digits entered on switches or produced by the BCD adder stage. It converts the value to an unsigned binary integer one digit per clock, most-significant digit first, using acc = acc*10 + digit. A start/busy/done handshake connects it to the lab top level, which drives LEDR and HEX.

## Interface
- DIGITS, 3: number of BCD digits in bcd_in (≥1).
- BIN_W, 10: width of bin_out. Must be ≥ ceil(log2(10^DIGITS)) for exact results (10 for 3 digits).
- Clock  in  1  rising-edge system clock.
- Resetn  in  1  asynchronous, active-low reset.
- start  in  1  request conversion; sampled only when ready (IDLE or DONE).
- bcd_in  in  4*DIGITS  packed BCD; bits [4*DIGITS-1:4*DIGITS-4] are the MSD. Sampled with start.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: bin_out/err updated.
- bin_out  out  BIN_W  last converted value; held until the next done.
- err  out  1  last conversion contained a digit > 9; held with bin_out.

## Operation
- Reset (Resetn=0, async): state=IDLE; busy=0, done=0, err=0, bin_out=0; internal shift register, accumulator and digit counter cleared.
- States: IDLE, CONV, DONE.
- IDLE: on start=1, load bcd_in into the shift register, acc=0, count=0, err flag=0, and go to CONV. Otherwise stay in IDLE.
- CONV: each cycle:
  - Take the top nibble d.
  - acc <= (acc<<3) + (acc<<1) + d, computed in BIN_W bits, modulo 2^BIN_W.
  - Shift the register left 4 and increment count.
  - If d > 9, set the internal err flag (see Configuration).
  - After the DIGITS-th update, go to DONE.
- DONE, for one cycle: done=1, bin_out=acc (or 0 if the err flag is set), and err=err flag.
  - If start=1 in this cycle, reload and go to CONV (back-to-back). Otherwise go to IDLE.
- start while in CONV: ignored; bcd_in is not resampled.
- bin_out and err change only on the edge entering DONE.

## Timing
- start sampled at edge k. Accumulator updates happen at edges k+1..k+DIGITS.
- done=1 and the new bin_out/err are visible in the cycle after edge k+DIGITS. done drops at edge k+DIGITS+1 unless it is re-triggered.
- Latency from start to done = DIGITS+1 edges (4 for the default).
- busy=1 exactly while state=CONV (edges k+1 through k+DIGITS). busy=0 in DONE.
- Back-to-back throughput: one result every DIGITS+1 cycles.
- Resetn asserted mid-conversion: all outputs go to reset values immediately, with no done pulse. A new start is needed after release.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- BCD2BIN_ERR_CHECK_EN defined:
  - A digit > 9 sets the err flag.
  - The completed conversion reports err=1 and bin_out=0.
  - Timing is unchanged.
- BCD2BIN_ERR_CHECK_EN undefined:
  - err is tied to 0.
  - Invalid nibbles are accumulated arithmetically (0xA=10 … 0xF=15) with no flagging.
  - The digit comparator logic is removed.

## Test plan
- Reset, then start with bcd_in=12'h999 → done after 4 edges, bin_out=10'd999 (0x3E7), err=0, busy high for 3 cycles.
- bcd_in=12'h000 → bin_out=0; then bcd_in=12'h128 → bin_out=128. bin_out holds 0 between the two done pulses.
- bcd_in=12'h1A5:
  - with BCD2BIN_ERR_CHECK_EN → err=1, bin_out=0;
  - without it → err=0, bin_out=205.
- start pulsed again in the 2nd CONV cycle with bcd_in=12'h555 → ignored; the first result (e.g., 12'h042 → 42) is delivered unchanged with a single done.
- Back-to-back: start held high through DONE with 12'h007 then 12'h310 → done pulses 4 cycles apart, results 7 then 310.
- Resetn dropped for one cycle during CONV of 12'h999 → busy/done/err/bin_out go to 0 asynchronously with no done pulse. A later start of 12'h250 yields 250.

Source files
------------

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake and data bundle between the lab top level and the BCD-to-binary converter.
// master: the requester driving start/bcd_in; slave: the converter.
interface bcd_to_bin_seq_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first (acc = acc*10 + d).
// Define BCD2BIN_ERR_CHECK_EN to flag digits > 9 (err=1, bin_out=0); otherwise err is 0.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic            Clock,
    input  logic            Resetn,
    bcd_to_bin_seq_if.slave io_bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e             r_state, w_state_next;
    logic [BCD_W-1:0]   r_shift, w_shift_next;
    logic [BIN_W-1:0]   r_acc, w_acc_next, w_acc_step;
    logic [CNT_W-1:0]   r_count, w_count_next;
    logic               r_err_flag, w_err_flag_next, w_err_step;
    logic [BIN_W-1:0]   r_bin_out, w_bin_out_next;
    logic               r_err, w_err_next;
    logic               r_busy, r_done;
    logic [3:0]         w_digit;
    logic               w_digit_bad;

    assign w_digit    = r_shift[BCD_W-1 -: 4];
    // acc*10 as two shifts and an add; wraps modulo 2^BIN_W
    assign w_acc_step = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_digit);

`ifdef BCD2BIN_ERR_CHECK_EN
    assign w_digit_bad = (w_digit > 4'd9);
`else
    assign w_digit_bad = 1'b0;
`endif

    assign w_err_step = r_err_flag | w_digit_bad;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_acc_next      = r_acc;
        w_count_next    = r_count;
        w_err_flag_next = r_err_flag;
        w_bin_out_next  = r_bin_out;
        w_err_next      = r_err;
        unique case (r_state)
            StIdle, StDone: begin
                if (io_bus.start) begin
                    w_state_next    = StConv;
                    w_shift_next    = io_bus.bcd_in;
                    w_acc_next      = '0;
                    w_count_next    = '0;
                    w_err_flag_next = 1'b0;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StConv: begin
                w_acc_next      = w_acc_step;
                w_shift_next    = r_shift << 4;
                w_count_next    = r_count + CNT_W'(1);
                w_err_flag_next = w_err_step;
                if (r_count == LAST_CNT) begin
                    // results are captured only on the edge entering DONE
                    w_state_next   = StDone;
                    w_bin_out_next = w_err_step ? '0 : w_acc_step;
                    w_err_next     = w_err_step;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_shift    <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_err_flag <= 1'b0;
            r_bin_out  <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_shift    <= w_shift_next;
            r_acc      <= w_acc_next;
            r_count    <= w_count_next;
            r_err_flag <= w_err_flag_next;
            r_bin_out  <= w_bin_out_next;
            r_err      <= w_err_next;
            r_busy     <= (w_state_next == StConv);
            r_done     <= (w_state_next == StDone);
        end
    end

    assign io_bus.busy    = r_busy;
    assign io_bus.done    = r_done;
    assign io_bus.bin_out = r_bin_out;
    assign io_bus.err     = r_err;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed-vector bench for bcd_to_bin_seq (3 digits, 10-bit result).
// Expectations follow BCD2BIN_ERR_CHECK_EN when the bench is built with it defined.
module tb_bcd_to_bin_seq;
    logic Clock;
    logic Resetn;
    int   n_vec;
    int   n_bad;

    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

    bcd_to_bin_seq #(
        .DIGITS (3),
        .BIN_W  (10)
    ) u_dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .io_bus (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
        end
    endtask

    // Start one conversion and check latency, busy length, result and the done drop.
    task automatic run_conv(input string tag, input logic [11:0] bcd,
                            input logic [9:0] exp_bin, input logic exp_err);
        int edges;
        int busy_cnt;
        @(negedge Clock);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        edges     = 1;
        busy_cnt  = 0;
        while (!bus.done && edges < 12) begin
            busy_cnt += int'(bus.busy);
            @(posedge Clock);
            #1;
            edges++;
        end
        check_eq({tag, ".latency"}, edges, 4);
        check_eq({tag, ".busy_cycles"}, busy_cnt, 3);
        check_eq({tag, ".busy_in_done"}, bus.busy, 0);
        check_eq({tag, ".bin_out"}, bus.bin_out, exp_bin);
        check_eq({tag, ".err"}, bus.err, exp_err);
        @(posedge Clock);
        #1;
        check_eq({tag, ".done_drop"}, bus.done, 0);
    endtask

    initial begin
        int pulses;
        int first;
        int second;
        logic [9:0] b1;
        logic [9:0] b2;
        n_vec      = 0;
        n_bad      = 0;
        Resetn     = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        #7;
        check_eq("rst.busy", bus.busy, 0);
        check_eq("rst.done", bus.done, 0);
        check_eq("rst.err", bus.err, 0);
        check_eq("rst.bin_out", bus.bin_out, 0);
        @(negedge Clock);
        Resetn = 1'b1;

        run_conv("h999", 12'h999, 10'd999, 1'b0);
        run_conv("h000", 12'h000, 10'd0, 1'b0);
        repeat (3) @(posedge Clock);
        #1;
        check_eq("hold0.bin_out", bus.bin_out, 0);
        check_eq("hold0.done", bus.done, 0);
        run_conv("h128", 12'h128, 10'd128, 1'b0);
`ifdef BCD2BIN_ERR_CHECK_EN
        run_conv("h1A5", 12'h1A5, 10'd0, 1'b1);
`else
        run_conv("h1A5", 12'h1A5, 10'd205, 1'b0);
`endif

        // start re-pulsed during the 2nd CONV cycle must be ignored
        @(negedge Clock);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h042;
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        @(posedge Clock);
        #1;
        bus.start  = 1'b1;
        bus.bcd_in = 12'h555;
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) pulses++;
            @(posedge Clock);
            #1;
        end
        check_eq("ign.done_pulses", pulses, 1);
        check_eq("ign.bin_out", bus.bin_out, 42);
        check_eq("ign.err", bus.err, 0);

        // back-to-back: start held high through DONE
        @(negedge Clock);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h007;
        @(posedge Clock);
        #1;
        bus.bcd_in = 12'h310;
        first  = -1;
        second = -1;
        b1     = '0;
        b2     = '0;
        for (int i = 0; i < 16; i++) begin
            if (bus.done) begin
                if (first < 0) begin
                    first = i;
                    b1    = bus.bin_out;
                end else if (second < 0) begin
                    second    = i;
                    b2        = bus.bin_out;
                    bus.start = 1'b0;
                end
            end
            @(posedge Clock);
            #1;
        end
        bus.start = 1'b0;
        check_eq("b2b.first_at", first, 3);
        check_eq("b2b.spacing", second - first, 4);
        check_eq("b2b.first_bin", b1, 7);
        check_eq("b2b.second_bin", b2, 310);

        // asynchronous reset in the middle of a conversion
        @(negedge Clock);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h999;
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        @(posedge Clock);
        #1;
        check_eq("mid.busy_before", bus.busy, 1);
        Resetn = 1'b0;
        #1;
        check_eq("mid.busy", bus.busy, 0);
        check_eq("mid.done", bus.done, 0);
        check_eq("mid.err", bus.err, 0);
        check_eq("mid.bin_out", bus.bin_out, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock);
            #1;
            if (bus.done || bus.busy) pulses++;
        end
        check_eq("mid.no_activity", pulses, 0);
        run_conv("h250", 12'h250, 10'd250, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
